z80_ifetch_responder: RTL and testbench
=======================================

Z80_IFETCH_RESPONDER -- requirements
Module: z80_ifetch_responder

Interface
REQ-001 Parameter: TIMEOUT, 64, maximum cycles FILL waits for M_ack on one byte before abort.
REQ-002 Port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: RST  input  1  synchronous, active-high reset.
REQ-004 Port: I_MREQ  input  1  fetch request from fetcher, level-sensitive.
REQ-005 Port: I_addr  input  16  fetch byte address.
REQ-006 Port: I_data  output  8  fetched byte, valid when I_MREQ=1 and I_wait=0.
REQ-007 Port: I_wait  output  1  stall to fetcher; 1 = data not yet valid.
REQ-008 Port: INV  input  1  invalidate strobe, one cycle (code-space write).
REQ-009 Port: INV_addr  input  16  address written; compared on bits [15:2].
REQ-010 Port: M_req  output  1  backing-memory read request.
REQ-011 Port: M_addr  output  16  backing-memory byte address.
REQ-012 Port: M_data  input  8  backing-memory read data, valid with M_ack.
REQ-013 Port: M_ack  input  1  one-cycle acknowledge; consumes current M_addr.
REQ-014 Port: ERR  output  1  sticky timeout flag.

Function
REQ-015 Storage: one 4-byte line buffer, 14-bit tag (addr[15:2]), valid bit.
REQ-016 Hit = valid & (tag == I_addr[15:2]); evaluated combinationally from current inputs.
REQ-017 FSM states: IDLE, FILL, ABORT.
REQ-018 IDLE, I_MREQ=0: I_wait=0, M_req=0, I_data=8'h00.
REQ-019 IDLE, I_MREQ=1, hit: I_wait=0 same cycle, I_data=line[I_addr[1:0]]; zero-latency.
REQ-020 IDLE, I_MREQ=1, miss: I_wait=1 this cycle; next state FILL; latch fill_tag=I_addr[15:2], cnt=0, valid cleared.
REQ-021 FILL: I_wait=1, M_req=1 continuously, M_addr={fill_tag, cnt}; bytes filled in order 0,1,2,3 regardless of requested offset.
REQ-022 FILL, M_ack=1: line[cnt] <= M_data, cnt <= cnt+1 (2-bit), per-byte timer cleared; M_addr advances next cycle.
REQ-023 FILL, M_ack with cnt==3: tag <= fill_tag, valid <= 1 unless poisoned (REQ-027); next state IDLE; M_req=0 in IDLE.
REQ-024 Miss-to-data latency with zero-wait memory (M_ack in each FILL cycle): request seen in cycle N, FILL cycles N+1..N+4, hit with I_wait=0 in N+5.
REQ-025 In IDLE after fill, request re-evaluated against current I_addr; changed I_addr (flush) may miss and start a new fill.
REQ-026 INV while IDLE or ABORT and INV_addr[15:2]==tag: valid <= 0 next cycle; a hit evaluated in the same cycle as INV still returns old data.
REQ-027 INV during FILL with INV_addr[15:2]==fill_tag: set poison; on completion valid stays 0, returning IDLE forces refetch; poison clears on entering FILL.
REQ-028 INV with non-matching address: no effect.
REQ-029 Timer counts FILL cycles without M_ack; reaching TIMEOUT: M_req=0 next cycle, ERR <= 1, next state ABORT, valid stays 0.
REQ-030 ABORT: one cycle; I_wait=0, I_data=8'h00 (NOP) if I_MREQ=1; then IDLE.
REQ-031 ERR sticky; cleared only by RST.
REQ-032 I_MREQ dropping during FILL does not cancel the fill; fill completes normally.

Reset
REQ-033 RST=1 at any edge, including mid-FILL: state IDLE, valid=0, poison=0, cnt=0, timer=0, ERR=0, M_req=0, M_addr=16'h0000.
REQ-034 Outputs during and after reset: I_wait=0 until a miss is seen, I_data=8'h00; memory reply pending at reset is ignored.

Verification
REQ-035 Cold miss: I_addr=16'h0102, M_ack every cycle, M_data=8'hA0..A3 -> M_addr 0100,0101,0102,0103; I_wait=1 for 5 cycles; I_data=8'hA2 with I_wait=0 in cycle 6.
REQ-036 Sequential hits: after REQ-035, I_addr 0100..0103 consecutively -> I_wait=0 each cycle, I_data A0,A1,A2,A3; M_req stays 0.
REQ-037 Invalidate: line 0100 valid, INV=1 with INV_addr=16'h0101, then fetch 0100 -> miss, new fill; INV_addr=16'h0200 -> still hit.
REQ-038 Poison: INV_addr=16'h0103 asserted during fill of 0100 -> fill completes, then refetch of 0100, total 8 memory acks.
REQ-039 Timeout: TIMEOUT=4, M_ack never asserted -> M_req drops after 4 FILL cycles, ERR=1, one cycle I_wait=0 with I_data=8'h00, ERR held until RST.
REQ-040 Reset mid-fill: RST after 2 acks -> next cycle M_req=0, valid=0; fetch of same address refetches all 4 bytes.

Source files
------------

// File: rtl/z80_ifetch_responder_if.sv
// Fetcher-side and backing-memory-side signals of the instruction fetch responder.
// master = fetcher/memory environment, slave = the responder.
interface z80_ifetch_responder_if;
    logic        I_MREQ;
    logic [15:0] I_addr;
    logic [7:0]  I_data;
    logic        I_wait;
    logic        INV;
    logic [15:0] INV_addr;
    logic        M_req;
    logic [15:0] M_addr;
    logic [7:0]  M_data;
    logic        M_ack;
    logic        ERR;

    modport master (
        output I_MREQ, I_addr, INV, INV_addr, M_data, M_ack,
        input  I_data, I_wait, M_req, M_addr, ERR
    );

    modport slave (
        input  I_MREQ, I_addr, INV, INV_addr, M_data, M_ack,
        output I_data, I_wait, M_req, M_addr, ERR
    );
endinterface

// File: rtl/z80_ifetch_responder.sv
// Single-line (4-byte) instruction fetch buffer: zero-latency hits, in-order line fill
// from backing memory, code-write invalidation with fill poisoning, and per-byte timeout.
module z80_ifetch_responder #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic                   CLK,
    input logic                   RST,
    z80_ifetch_responder_if.slave bus
);

    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFill, StAbort} state_e;

    state_e            state_q, state_d;
    logic [7:0]        line_q [4];
    logic [7:0]        line_d [4];
    logic [13:0]       tag_q, tag_d;
    logic              valid_q, valid_d;
    logic [13:0]       fill_tag_q, fill_tag_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              poison_q, poison_d;
    logic              err_q, err_d;

    logic       hit;
    logic       inv_tag;
    logic       inv_fill;
    logic       i_wait;
    logic [7:0] i_data;
    logic       m_req;

    assign hit      = valid_q && (tag_q == bus.I_addr[15:2]);
    assign inv_tag  = bus.INV && (bus.INV_addr[15:2] == tag_q);
    assign inv_fill = bus.INV && (bus.INV_addr[15:2] == fill_tag_q);

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        fill_tag_d = fill_tag_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        poison_d   = poison_q;
        err_d      = err_q;
        i_wait     = 1'b0;
        i_data     = 8'h00;
        m_req      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (inv_tag) begin
                    valid_d = 1'b0;
                end
                if (bus.I_MREQ) begin
                    if (hit) begin
                        i_data = line_q[bus.I_addr[1:0]];
                    end else begin
                        i_wait     = 1'b1;
                        state_d    = StFill;
                        fill_tag_d = bus.I_addr[15:2];
                        cnt_d      = 2'd0;
                        timer_d    = '0;
                        valid_d    = 1'b0;
                        poison_d   = 1'b0;
                    end
                end
            end
            StFill: begin
                i_wait = 1'b1;
                m_req  = 1'b1;
                if (inv_fill) begin
                    poison_d = 1'b1;
                end
                if (bus.M_ack) begin
                    line_d[cnt_q] = bus.M_data;
                    cnt_d         = cnt_q + 2'd1;
                    timer_d       = '0;
                    if (cnt_q == 2'd3) begin
                        tag_d   = fill_tag_q;
                        // A write landing in the final cycle may already be stale in the line.
                        valid_d = !(poison_q || inv_fill);
                        state_d = StIdle;
                    end
                end else if (timer_q == TimerLast) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = StAbort;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StAbort: begin
                if (inv_tag) begin
                    valid_d = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (RST) begin
            i_wait = 1'b0;
            i_data = 8'h00;
            m_req  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            line_q     <= '{default: 8'h00};
            tag_q      <= '0;
            valid_q    <= 1'b0;
            fill_tag_q <= '0;
            cnt_q      <= 2'd0;
            timer_q    <= '0;
            poison_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            fill_tag_q <= fill_tag_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            poison_q   <= poison_d;
            err_q      <= err_d;
        end
    end

    assign bus.I_wait = i_wait;
    assign bus.I_data = i_data;
    assign bus.M_req  = m_req;
    assign bus.M_addr = {fill_tag_q, cnt_q};
    assign bus.ERR    = err_q;

endmodule

// File: tb/tb_z80_ifetch_responder.sv
// Directed scenarios for the fetch buffer, then randomized traffic checked against a
// flat memory image: every accepted fetch must return the current memory byte.
module tb_z80_ifetch_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ack_cnt = 0;

    logic [7:0] mem [65536];

    z80_ifetch_responder_if bus ();

    z80_ifetch_responder #(
        .TIMEOUT (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.M_req && bus.M_ack) ack_cnt <= ack_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.I_MREQ   = 1'b0;
        bus.I_addr   = 16'h0000;
        bus.INV      = 1'b0;
        bus.INV_addr = 16'h0000;
        bus.M_data   = 8'h00;
        bus.M_ack    = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        check_eq("rst_i_wait", 16'(bus.I_wait), 16'd0);
        check_eq("rst_i_data", 16'(bus.I_data), 16'h00);
        check_eq("rst_m_req", 16'(bus.M_req), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_m_addr", bus.M_addr, 16'h0000);
        check_eq("post_rst_err", 16'(bus.ERR), 16'd0);
        check_eq("post_rst_m_req", 16'(bus.M_req), 16'd0);
        check_eq("post_rst_i_wait", 16'(bus.I_wait), 16'd0);
    endtask

    task automatic miss_cycle(input logic [15:0] addr);
        @(negedge clk);
        bus.I_MREQ = 1'b1;
        bus.I_addr = addr;
        bus.M_ack  = 1'b0;
        bus.INV    = 1'b0;
        #1;
        check_eq("miss_i_wait", 16'(bus.I_wait), 16'd1);
        check_eq("miss_m_req", 16'(bus.M_req), 16'd0);
    endtask

    // Four zero-wait fill cycles; optionally pulse INV on step inv_step.
    task automatic fill_line(input logic [15:0] base, input logic [7:0] d0,
                             input int inv_step, input logic [15:0] inv_addr);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.INV      = (k == inv_step);
            bus.INV_addr = inv_addr;
            bus.M_ack    = 1'b1;
            bus.M_data   = d0 + 8'(k);
            #1;
            check_eq("fill_m_req", 16'(bus.M_req), 16'd1);
            check_eq("fill_m_addr", bus.M_addr, base + 16'(k));
            check_eq("fill_i_wait", 16'(bus.I_wait), 16'd1);
        end
    endtask

    task automatic hit_cycle(input logic [15:0] addr, input logic [7:0] exp);
        @(negedge clk);
        bus.M_ack  = 1'b0;
        bus.INV    = 1'b0;
        bus.I_MREQ = 1'b1;
        bus.I_addr = addr;
        #1;
        check_eq("hit_i_wait", 16'(bus.I_wait), 16'd0);
        check_eq("hit_i_data", 16'(bus.I_data), 16'(exp));
        check_eq("hit_m_req", 16'(bus.M_req), 16'd0);
    endtask

    task automatic random_phase(input int cycles);
        bit         holding = 1'b0;
        int         wait_cyc = 0;
        int         gap = 0;
        logic [1:0] ab = 2'd0;
        bit         ack;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!holding) begin
                bus.I_MREQ = ($urandom_range(3) != 0);
                if ($urandom_range(1) == 1)
                    bus.I_addr = 16'h0100 + ((bus.I_addr - 16'h0100 + 16'd1) & 16'h001F);
                else
                    bus.I_addr = 16'h0100 + 16'($urandom_range(31));
            end
            bus.INV      = ($urandom_range(15) == 0);
            bus.INV_addr = 16'h0100 + 16'($urandom_range(31));
            #1;
            ack = 1'b0;
            if (bus.M_req) ack = (gap >= 2) || ($urandom_range(1) == 1);
            bus.M_ack  = ack;
            bus.M_data = mem[bus.M_addr];
            if (ack) begin
                check_eq("rnd_ack_addr", bus.M_addr, {bus.I_addr[15:2], ab});
                ab++;
                gap = 0;
            end else if (bus.M_req) begin
                gap++;
            end
            #1;
            check_eq("rnd_err", 16'(bus.ERR), 16'd0);
            if (bus.I_MREQ) begin
                if (!bus.I_wait) begin
                    check_eq("rnd_fetch_data", 16'(bus.I_data), 16'(mem[bus.I_addr]));
                    holding  = 1'b0;
                    wait_cyc = 0;
                end else begin
                    holding = 1'b1;
                    wait_cyc++;
                    if (wait_cyc == 61) check_eq("rnd_fetch_bound", 16'(wait_cyc), 16'd60);
                end
            end else begin
                check_eq("rnd_idle_wait", 16'(bus.I_wait), 16'd0);
                check_eq("rnd_idle_data", 16'(bus.I_data), 16'h00);
            end
            if (bus.INV) mem[bus.INV_addr] = 8'($urandom);
        end
    endtask

    initial begin
        int snap;
        idle_inputs();
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

        reset_dut();

        // Cold miss then sequential hits
        miss_cycle(16'h0102);
        fill_line(16'h0100, 8'hA0, -1, 16'h0000);
        hit_cycle(16'h0102, 8'hA2);
        for (int k = 0; k < 4; k++) hit_cycle(16'h0100 + 16'(k), 8'hA0 + 8'(k));

        // Invalidate: non-matching ignored, matching keeps same-cycle hit then misses
        @(negedge clk);
        bus.I_addr   = 16'h0100;
        bus.INV      = 1'b1;
        bus.INV_addr = 16'h0200;
        #1;
        check_eq("inv_other_data", 16'(bus.I_data), 16'hA0);
        hit_cycle(16'h0101, 8'hA1);
        @(negedge clk);
        bus.INV      = 1'b1;
        bus.INV_addr = 16'h0101;
        bus.I_addr   = 16'h0101;
        #1;
        check_eq("inv_same_cycle_wait", 16'(bus.I_wait), 16'd0);
        check_eq("inv_same_cycle_data", 16'(bus.I_data), 16'hA1);
        miss_cycle(16'h0100);
        fill_line(16'h0100, 8'hB0, -1, 16'h0000);
        hit_cycle(16'h0100, 8'hB0);

        // Poisoned fill forces an immediate refetch
        miss_cycle(16'h0300);
        fill_line(16'h0300, 8'hC0, -1, 16'h0000);
        hit_cycle(16'h0301, 8'hC1);
        snap = ack_cnt;
        miss_cycle(16'h0100);
        fill_line(16'h0100, 8'hD0, 1, 16'h0103);
        @(negedge clk);
        bus.M_ack = 1'b0;
        bus.INV   = 1'b0;
        #1;
        check_eq("poison_refetch_wait", 16'(bus.I_wait), 16'd1);
        check_eq("poison_refetch_m_req", 16'(bus.M_req), 16'd0);
        fill_line(16'h0100, 8'hE0, -1, 16'h0000);
        hit_cycle(16'h0100, 8'hE0);
        check_eq("poison_ack_total", 16'(ack_cnt - snap), 16'd8);

        // Reset in the middle of a fill
        miss_cycle(16'h0400);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.M_ack  = 1'b1;
            bus.M_data = 8'h90 + 8'(k);
        end
        @(negedge clk);
        rst        = 1'b1;
        bus.M_data = 8'hEE;
        #1;
        check_eq("midrst_m_req", 16'(bus.M_req), 16'd0);
        check_eq("midrst_i_wait", 16'(bus.I_wait), 16'd0);
        check_eq("midrst_i_data", 16'(bus.I_data), 16'h00);
        @(negedge clk);
        rst       = 1'b0;
        bus.M_ack = 1'b0;
        #1;
        check_eq("midrst_refetch_wait", 16'(bus.I_wait), 16'd1);
        check_eq("midrst_m_addr", bus.M_addr, 16'h0000);
        fill_line(16'h0400, 8'hF0, -1, 16'h0000);
        hit_cycle(16'h0403, 8'hF3);

        // Timeout with no memory acknowledge
        miss_cycle(16'h0500);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.M_ack = 1'b0;
            #1;
            check_eq("to_m_req", 16'(bus.M_req), 16'd1);
            check_eq("to_err_early", 16'(bus.ERR), 16'd0);
        end
        @(negedge clk);
        #1;
        check_eq("abort_m_req", 16'(bus.M_req), 16'd0);
        check_eq("abort_i_wait", 16'(bus.I_wait), 16'd0);
        check_eq("abort_i_data", 16'(bus.I_data), 16'h00);
        check_eq("abort_err", 16'(bus.ERR), 16'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.I_MREQ = 1'b0;
            #1;
            check_eq("err_sticky", 16'(bus.ERR), 16'd1);
            check_eq("post_abort_m_req", 16'(bus.M_req), 16'd0);
        end
        reset_dut();

        random_phase(3000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
